stck_que: RTL and testbench
===========================

STCK_QUE -- requirements
Module: stck_que

Interface
REQ-001 Parameter DATA_W, default 8, width of one stored location.
REQ-002 Parameter DEPTH, default 256, maximum number of stored entries (power of two).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 locIn  input  DATA_W  location to store on push.
REQ-006 push  input  1  store locIn this cycle.
REQ-007 pop  input  1  remove the entry currently shown on locOut.
REQ-008 done  input  1  one-cycle pulse; switches from stack (LIFO) to queue (FIFO) read order.
REQ-009 locOut  output  DATA_W  entry that the next pop removes (combinational peek).
REQ-010 empStck  output  1  high when zero entries are stored.

Function
REQ-011 Storage SHALL be an array of DEPTH entries with a bottom pointer, a top pointer and a count 0..DEPTH.
REQ-012 Mode SHALL be a two-state FSM: STACK (after reset) -> QUEUE on any cycle with done=1; QUEUE holds until rst; done in QUEUE is ignored.
REQ-013 push (accepted) SHALL write locIn at top and increment count, in both modes.
REQ-014 In STACK, locOut SHALL show the newest entry and pop SHALL remove it (LIFO).
REQ-015 In QUEUE, locOut SHALL show the oldest entry and pop SHALL remove it (FIFO, bottom pointer advances).
REQ-016 Push and pop take effect at the rising edge where they are sampled high; locOut/empStck reflect the new state in the same cycle after that edge (zero-cycle peek, one-edge update).
REQ-017 locOut SHALL be 0 when empty.
REQ-018 empStck SHALL equal (count == 0), combinationally from registered count.
REQ-019 pop when empty SHALL be ignored; push when count == DEPTH SHALL be ignored; contents unchanged.
REQ-020 push and pop high in the same cycle: push SHALL win, pop ignored.
REQ-021 done and pop in the same cycle: mode switches first; the pop SHALL remove the oldest entry (QUEUE order).
REQ-022 done and push in the same cycle: both take effect.
REQ-023 Pointers SHALL wrap modulo DEPTH; a QUEUE-mode pop followed by pushes reuses freed slots.

Reset
REQ-024 rst SHALL set count=0, both pointers=0, mode=STACK; locOut=0, empStck=1 after the edge.
REQ-025 rst SHALL override push, pop and done in the same cycle, including mid-operation with stored data.
REQ-026 Memory contents need not be cleared by reset.

Structure
REQ-027 A shared package SHALL hold DATA_W, DEPTH, pointer width (log2 DEPTH) and the mode enum {STACK, QUEUE}.
REQ-028 One sub-module stck_que_mem (single-write, asynchronous-read register file) SHALL hold the array; pointer/count/FSM logic in stck_que.

Verification
REQ-029 Reset, push 0x40, push 0x01, pop -> locOut=0x40, empStck=0, count 1.
REQ-030 Continue: push 0x40, push 0xA3 -> locOut=0xA3; done pulse -> locOut=0x40; pop x3 -> outputs 0x40, 0x40, 0xA3 in order, then empStck=1, locOut=0.
REQ-031 Pop on empty (STACK and QUEUE) -> no change, empStck stays 1.
REQ-032 Push DEPTH values 0..255, push 0x77 -> ignored, locOut=0xFF; pop all -> 0xFF down to 0x00.
REQ-033 push 0x10 with pop simultaneously on stack [0x05] -> stack [0x05,0x10], locOut=0x10.
REQ-034 QUEUE mode with data, rst pulse -> empStck=1, mode STACK; push 0x01, push 0x02 -> locOut=0x02.

Source files
------------

// File: rtl/stck_que_pkg.sv
// Shared constants and the read-order mode type for the stack/queue store.
// The parameterised modules default to these values.
package stck_que_pkg;

   localparam int PKG_DATA_W = 8;
   localparam int PKG_DEPTH  = 256;
   localparam int PKG_PTR_W  = $clog2(PKG_DEPTH);

   typedef enum logic {
      STACK = 1'b0,
      QUEUE = 1'b1
   } mode_e;

endpackage

// File: rtl/stck_que_if.sv
// Command/peek bundle between a producer (master) and the stck_que store (slave).
interface stck_que_if
   import stck_que_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W
);

   logic [DATA_W-1:0] locIn;
   logic              push;
   logic              pop;
   logic              done;
   logic [DATA_W-1:0] locOut;
   logic              empStck;

   modport master (
      output locIn, push, pop, done,
      input  locOut, empStck
   );

   modport slave (
      input  locIn, push, pop, done,
      output locOut, empStck
   );

endinterface

// File: rtl/stck_que_mem.sv
// Register file with one synchronous write port and one asynchronous read port.
// The contents are deliberately left uninitialised at reset.
module stck_que_mem
   import stck_que_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int DEPTH  = PKG_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stck_que.sv
// Location store that reads back newest-first (STACK) until a done pulse,
// then oldest-first (QUEUE) until reset. Pointers and count live here.
module stck_que
   import stck_que_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int DEPTH  = PKG_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   stck_que_if.slave                bus,
   output mode_e                    dbg_mode,
   output logic [$clog2(DEPTH):0]   dbg_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

   // Command semantics: push/pop are single-cycle requests taken at the edge
   // where they are high. push is accepted unless full; pop is accepted when
   // not empty and push is low. locOut peeks the entry the next pop removes.

   mode_e             mode;
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  bot_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W-1:0]  raddr;
   logic [DATA_W-1:0] rdata;
   logic              empty;
   logic              full;
   logic              do_push;
   logic              do_pop;
   logic              pop_fifo;

   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);
   assign do_push  = bus.push && !full;
   assign do_pop   = bus.pop && !bus.push && !empty;
   // A done arriving with a pop already selects oldest-first for that pop.
   assign pop_fifo = (mode == QUEUE) || bus.done;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode    <= STACK;
         top_ptr <= '0;
         bot_ptr <= '0;
         count   <= '0;
      end else begin
         case (mode)
            STACK:   if (bus.done) mode <= QUEUE;
            QUEUE:   mode <= QUEUE;
            default: mode <= STACK;
         endcase

         if (do_push) begin
            top_ptr <= top_ptr + PTR_ONE;
            count   <= count + CNT_ONE;
         end else if (do_pop) begin
            count <= count - CNT_ONE;
            if (pop_fifo) begin
               bot_ptr <= bot_ptr + PTR_ONE;
            end else begin
               top_ptr <= top_ptr - PTR_ONE;
            end
         end
      end
   end

   assign raddr = (mode == QUEUE) ? bot_ptr : (top_ptr - PTR_ONE);

   stck_que_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (top_ptr),
      .wdata (bus.locIn),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign bus.locOut  = empty ? '0 : rdata;
   assign bus.empStck = empty;
   assign dbg_mode    = mode;
   assign dbg_count   = count;

endmodule

// File: tb/tb_stck_que.sv
// Self-checking bench for stck_que: a contents model drives an expected queue
// of popped values, and every cycle the peek/empty/count/mode are compared.
module tb_stck_que;
   import stck_que_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 256;

   logic clk;
   logic rst;
   mode_e dbg_mode;
   logic [$clog2(DEPTH):0] dbg_count;

   stck_que_if #(.DATA_W(DW)) bus ();

   stck_que #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_mode  (dbg_mode),
      .dbg_count (dbg_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] m_q [$];
   logic          m_queue;
   int            n_cmp;
   int            n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_peek();
      if (m_q.size() == 0) return '0;
      return m_queue ? m_q[0] : m_q[m_q.size()-1];
   endfunction

   task automatic check_state();
      check("peek",  32'(bus.locOut),  32'(model_peek()));
      check("empty", 32'(bus.empStck), 32'(m_q.size() == 0));
      check("count", 32'(dbg_count),   32'(m_q.size()));
      check("mode",  32'(dbg_mode),    32'(m_queue ? QUEUE : STACK));
   endtask

   // one cycle of stimulus; inputs driven at negedge, checked #1 after posedge
   task automatic step(input logic p, input logic q, input logic d, input logic [DW-1:0] v);
      @(negedge clk);
      bus.push  = p;
      bus.pop   = q;
      bus.done  = d;
      bus.locIn = v;
      if (q && !p && m_q.size() != 0 && (m_queue || !d)) begin
         exp_q.push_back(m_queue ? m_q[0] : m_q[m_q.size()-1]);
         check("pop_data", 32'(bus.locOut), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.done = 1'b0;
      if (d) m_queue = 1'b1;
      if (p) begin
         if (m_q.size() < DEPTH) m_q.push_back(v);
      end else if (q && m_q.size() != 0) begin
         if (m_queue) void'(m_q.pop_front());
         else         void'(m_q.pop_back());
      end
      check_state();
   endtask

   task automatic do_rst(input logic p, input logic q, input logic d, input logic [DW-1:0] v);
      @(negedge clk);
      rst       = 1'b1;
      bus.push  = p;
      bus.pop   = q;
      bus.done  = d;
      bus.locIn = v;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.done = 1'b0;
      m_q.delete();
      m_queue = 1'b0;
      check("rst_empty", 32'(bus.empStck), 32'd1);
      check("rst_peek",  32'(bus.locOut),  32'd0);
      check_state();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      m_queue   = 1'b0;
      rst       = 1'b1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.done  = 1'b0;
      bus.locIn = '0;
      repeat (2) @(posedge clk);
      do_rst(1'b0, 1'b0, 1'b0, 8'h00);

      // LIFO basics
      step(1'b1, 1'b0, 1'b0, 8'h40);
      step(1'b1, 1'b0, 1'b0, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("r029_peek", 32'(bus.locOut), 32'h40);
      check("r029_cnt",  32'(dbg_count),  32'd1);

      // switch to FIFO order and drain
      step(1'b1, 1'b0, 1'b0, 8'h40);
      step(1'b1, 1'b0, 1'b0, 8'hA3);
      check("r030_top", 32'(bus.locOut), 32'hA3);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("r030_old", 32'(bus.locOut), 32'h40);
      repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);
      check("r030_emp",  32'(bus.empStck), 32'd1);
      check("r030_zero", 32'(bus.locOut),  32'd0);

      // pop on empty, both modes
      step(1'b0, 1'b1, 1'b0, 8'h00);
      do_rst(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("r031_emp", 32'(bus.empStck), 32'd1);

      // full stack, overflow push ignored, drain newest first
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
      step(1'b1, 1'b0, 1'b0, 8'h77);
      check("r032_full", 32'(bus.locOut), 32'hFF);
      check("r032_cnt",  32'(dbg_count),  32'd256);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      check("r032_emp", 32'(bus.empStck), 32'd1);

      // push wins over pop
      step(1'b1, 1'b0, 1'b0, 8'h05);
      step(1'b1, 1'b1, 1'b0, 8'h10);
      check("r033_peek", 32'(bus.locOut), 32'h10);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("r033_left", 32'(bus.locOut), 32'h05);

      // done with pop removes the oldest entry
      do_rst(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h01);
      step(1'b1, 1'b0, 1'b0, 8'h02);
      step(1'b1, 1'b0, 1'b0, 8'h03);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("r021_peek", 32'(bus.locOut), 32'h02);

      // done with push: both take effect
      do_rst(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'hAA);
      step(1'b1, 1'b0, 1'b1, 8'hBB);
      check("r022_peek", 32'(bus.locOut), 32'hAA);
      check("r022_cnt",  32'(dbg_count),  32'd2);

      // FIFO pointer wrap: fill, free some slots, refill, drain in order
      do_rst(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i ^ 8'h5A));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
      check("wrap_cnt", 32'(dbg_count), 32'd256);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

      // reset in QUEUE mode with data and all commands high
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
      do_rst(1'b1, 1'b1, 1'b1, 8'h33);
      check("r034_mode", 32'(dbg_mode), 32'(STACK));
      step(1'b1, 1'b0, 1'b0, 8'h01);
      step(1'b1, 1'b0, 1'b0, 8'h02);
      check("r034_peek", 32'(bus.locOut), 32'h02);

      // random traffic, done pulsed once midway
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              (i == 300), DW'($urandom_range(0, 255)));
      end

      if (exp_q.size() != 0) check("exp_q_left", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
